// File: rtl/nap_alarm_pkg.sv
// Shared types and helpers for the nap alarm sequencer.
package nap_alarm_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  // Bits needed to hold 0..range-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned range);
    return (range <= 1) ? 1 : int'($clog2(range));
  endfunction

endpackage

// File: rtl/alarm_tick_div.sv
// Clock prescaler: one-clock tick every CLK_DIV enabled clocks, synchronous clear.
module alarm_tick_div
  import nap_alarm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick = enable && (div_cnt == DIV_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear || !enable || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nap_alarm_seq.sv
// Programmable blink-pattern alarm sequencer with prescaler, burst limit and snooze.
// Snooze support is built only when NAP_ALARM_SNOOZE_EN is defined.
module nap_alarm_seq
  import nap_alarm_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned PERIOD       = 3,
  parameter int unsigned ON_STEPS     = 1,
  parameter int unsigned CYCLES       = 4,
  parameter int unsigned MAX_BURSTS   = 0,
  parameter int unsigned SNOOZE_STEPS = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       snooze,
  output logic       light,
  output logic       active,
  output logic       done,
  output logic [1:0] state_o
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("CLK_DIV must be >= 1");
  end
  if (PERIOD < 1) begin : g_bad_period
    $error("PERIOD must be >= 1");
  end
  if (ON_STEPS < 1 || ON_STEPS > PERIOD) begin : g_bad_on_steps
    $error("ON_STEPS must be in 1..PERIOD");
  end
  if (CYCLES < 1) begin : g_bad_cycles
    $error("CYCLES must be >= 1");
  end
  if (SNOOZE_STEPS < 1) begin : g_bad_snooze_steps
    $error("SNOOZE_STEPS must be >= 1");
  end

  localparam int unsigned SW          = cnt_w(PERIOD);
  localparam int unsigned CW          = cnt_w(CYCLES);
  // With no burst limit the counter only needs to saturate, so give it two codes.
  localparam int unsigned BURST_RANGE = (MAX_BURSTS == 0) ? 2 : MAX_BURSTS;
  localparam int unsigned BW          = cnt_w(BURST_RANGE);

  localparam logic [SW-1:0] STEP_LAST  = SW'(PERIOD - 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(CYCLES - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_RANGE - 1);

  state_t        state, state_nx;
  logic [SW-1:0] step_cnt, step_nx;
  logic [CW-1:0] cycle_cnt, cycle_nx;
  logic [BW-1:0] burst_cnt, burst_nx;
  logic          done_q, done_nx;
  logic          clr_all;
  logic          tick;
  logic          div_en;
  logic          div_clear;

`ifdef NAP_ALARM_SNOOZE_EN
  localparam int unsigned NW = cnt_w(SNOOZE_STEPS);
  localparam logic [NW-1:0] SNZ_LOAD = NW'(SNOOZE_STEPS - 1);
  logic [NW-1:0] snz_cnt, snz_nx;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  assign div_en    = (state == RING) || (state == SNOOZE);
  assign div_clear = (state_nx != state);

  alarm_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clock  (clock),
    .reset  (reset),
    .clear  (div_clear),
    .enable (div_en),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      step_cnt  <= '0;
      cycle_cnt <= '0;
      burst_cnt <= '0;
      done_q    <= 1'b0;
`ifdef NAP_ALARM_SNOOZE_EN
      snz_cnt   <= '0;
`endif
    end else begin
      state     <= state_nx;
      step_cnt  <= step_nx;
      cycle_cnt <= cycle_nx;
      burst_cnt <= burst_nx;
      done_q    <= done_nx;
`ifdef NAP_ALARM_SNOOZE_EN
      snz_cnt   <= snz_nx;
`endif
    end
  end

  // Priority inside each state: stop, then snooze, then start/tick.
  always_comb begin
    state_nx = state;
    step_nx  = step_cnt;
    cycle_nx = cycle_cnt;
    burst_nx = burst_cnt;
    done_nx  = 1'b0;
    clr_all  = 1'b0;
`ifdef NAP_ALARM_SNOOZE_EN
    snz_nx   = snz_cnt;
`endif
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx = RING;
          clr_all  = 1'b1;
        end
      end
      RING: begin
        if (stop) begin
          state_nx = IDLE;
          clr_all  = 1'b1;
        end
`ifdef NAP_ALARM_SNOOZE_EN
        else if (snooze) begin
          state_nx = SNOOZE;
          snz_nx   = SNZ_LOAD;
        end
`endif
        else if (tick) begin
          if (step_cnt == STEP_LAST) begin
            step_nx = '0;
            if (cycle_cnt == CYC_LAST) begin
              cycle_nx = '0;
              if (MAX_BURSTS != 0 && burst_cnt == BURST_LAST) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
                clr_all  = 1'b1;
              end else if (burst_cnt != BURST_LAST) begin
                burst_nx = burst_cnt + 1'b1;
              end
            end else begin
              cycle_nx = cycle_cnt + 1'b1;
            end
          end else begin
            step_nx = step_cnt + 1'b1;
          end
        end
      end
`ifdef NAP_ALARM_SNOOZE_EN
      SNOOZE: begin
        if (stop) begin
          state_nx = IDLE;
          clr_all  = 1'b1;
        end else if (!snooze && start) begin
          state_nx = RING;
          step_nx  = '0;
          cycle_nx = '0;
        end else if (tick) begin
          if (snz_cnt == '0) begin
            state_nx = RING;
            step_nx  = '0;
            cycle_nx = '0;
          end else begin
            snz_nx = snz_cnt - 1'b1;
          end
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        clr_all  = 1'b1;
      end
    endcase
    if (clr_all) begin
      step_nx  = '0;
      cycle_nx = '0;
      burst_nx = '0;
`ifdef NAP_ALARM_SNOOZE_EN
      snz_nx   = '0;
`endif
    end
  end

  always_comb begin
    light   = (state == RING) && (32'(step_cnt) < ON_STEPS);
    active  = (state == RING) || (state == SNOOZE);
    done    = done_q;
    state_o = state;
  end

endmodule

// File: tb/tb_nap_alarm_seq.sv
// Scoreboard bench: three differently configured sequencers against an elapsed-time model.
module tb_nap_alarm_seq;

  localparam int unsigned NI = 3;
  localparam int unsigned CD  [NI] = '{1, 1, 4};
  localparam int unsigned PER [NI] = '{3, 3, 4};
  localparam int unsigned ON  [NI] = '{1, 1, 2};
  localparam int unsigned CYC [NI] = '{4, 4, 2};
  localparam int unsigned MB  [NI] = '{0, 2, 3};
  localparam int unsigned SS  [NI] = '{24, 5, 3};
`ifdef NAP_ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic clock, reset, start, stop, snooze;
  logic       light_w  [NI];
  logic       active_w [NI];
  logic       done_w   [NI];
  logic [1:0] state_w  [NI];

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 ring, 2 snooze; e = clocks since ring (re)entry, r = snooze clocks left.
  int unsigned m_st [NI];
  int unsigned m_e  [NI];
  int unsigned m_b  [NI];
  int unsigned m_r  [NI];
  bit          m_done [NI];

  logic [NI*5-1:0] exp_q[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    nap_alarm_seq #(
      .CLK_DIV      (CD[g]),
      .PERIOD       (PER[g]),
      .ON_STEPS     (ON[g]),
      .CYCLES       (CYC[g]),
      .MAX_BURSTS   (MB[g]),
      .SNOOZE_STEPS (SS[g])
    ) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .stop    (stop),
      .snooze  (snooze),
      .light   (light_w[g]),
      .active  (active_w[g]),
      .done    (done_w[g]),
      .state_o (state_w[g])
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [4:0] got(input int k);
    return {light_w[k], active_w[k], done_w[k], state_w[k]};
  endfunction

  function automatic logic [4:0] model_out(input int k);
    logic l;
    l = (m_st[k] == 1) && (((m_e[k] / CD[k]) % PER[k]) < ON[k]);
    return {l, m_st[k] != 0, m_done[k], 2'(m_st[k])};
  endfunction

  task automatic check(input string name, input int k, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d {light,active,done,state}: got %b expected %b at %0t",
               name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_st[k] = 0; m_e[k] = 0; m_b[k] = 0; m_r[k] = 0; m_done[k] = 1'b0;
  endtask

  task automatic model_edge(input int k, input bit st, input bit sp, input bit sz);
    m_done[k] = 1'b0;
    case (m_st[k])
      0: if (st && !sp) begin
        m_st[k] = 1; m_e[k] = 0; m_b[k] = 0;
      end
      1: begin
        if (sp) model_reset(k);
        else if (SNZ_EN && sz) begin
          m_st[k] = 2; m_r[k] = SS[k] * CD[k];
        end else begin
          m_e[k]++;
          if (m_e[k] == CD[k] * PER[k] * CYC[k]) begin
            m_e[k] = 0;
            m_b[k]++;
            if (MB[k] != 0 && m_b[k] == MB[k]) begin
              model_reset(k);
              m_done[k] = 1'b1;
            end
          end
        end
      end
      default: begin
        if (sp) model_reset(k);
        else if (!sz && st) begin
          m_st[k] = 1; m_e[k] = 0;
        end else begin
          m_r[k]--;
          if (m_r[k] == 0) begin
            m_st[k] = 1; m_e[k] = 0;
          end
        end
      end
    endcase
  endtask

  task automatic drive(input bit rst_n, input bit st, input bit sp, input bit sz);
    logic [NI*5-1:0] e;
    @(negedge clock);
    reset = rst_n; start = st; stop = sp; snooze = sz;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) model_reset(k);
      else model_edge(k, st, sp, sz);
      e[k*5 +: 5] = model_out(k);
    end
    exp_q.push_back(e);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset_check();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("async_reset", k, got(k), 5'b0);
      model_reset(k);
    end
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    logic [NI*5-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NI; k++) check("cycle", k, got(k), e[k*5 +: 5]);
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; snooze = 1'b0;
    for (int k = 0; k < NI; k++) model_reset(k);

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    quiet(104);

    drive(1'b1, 1'b1, 1'b0, 1'b0);
    quiet(1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    quiet(8);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    quiet(3);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    quiet(2);
    drive(1'b1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      drive(1'b1, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 29) == 0);
    end

    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    quiet(3);
    async_reset_check();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    quiet(5);

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nap_alarm_seq.md
Name: nap_alarm_seq

Overview:
- Parametrised successor to the fixed 12-step alarm FSM.
- Generates a programmable blink pattern on `light` once armed by `start`, until `stop` or an optional burst limit.
- Adds a clock prescaler, configurable on/off duty, burst counting with auto-stop, and a snooze state.
- Sits between the nap timer control and the indicator LED driver.

Parameters:
- CLK_DIV, 1, clocks per pattern step (>=1).
- PERIOD, 3, steps per blink cycle (>=1).
- ON_STEPS, 1, steps per cycle with light high (1..PERIOD).
- CYCLES, 4, blink cycles per burst (>=1).
- MAX_BURSTS, 0, bursts before auto-stop; 0 means ring forever.
- SNOOZE_STEPS, 24, steps spent silent in SNOOZE (>=1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low.
- start  input  1  level, sampled each clock; arms the alarm.
- stop  input  1  level, sampled each clock; silences the alarm.
- snooze  input  1  level, sampled each clock; temporary silence.
- light  output  1  indicator drive.
- active  output  1  high in RING or SNOOZE.
- done  output  1  one-clock pulse on burst-limit auto-stop.
- state_o  output  2  current state encoding.

Behaviour:
- Interface: reset reset, asynchronous, active-low; clock clock.
- Reset: state=IDLE; all counters 0; light=0, active=0, done=0, state_o=IDLE.
- Outputs are Moore decodes of registered state only; no input-to-output combinational path. `done` is a register.
- States: IDLE=0, RING=1, SNOOZE=2; code 3 is illegal and returns to IDLE on the next edge.
- Input priority, evaluated every edge: stop > snooze > start.
- IDLE: start=1 -> RING with div/step/cycle/burst counters cleared. The next cycle shows light=1 (latency 1 clock).
- Tick generation:
  - div_cnt runs 0..CLK_DIV-1 in RING and SNOOZE only.
  - tick = (div_cnt==CLK_DIV-1).
  - div_cnt is cleared on every state entry.
- Step counting in RING: on tick, step_cnt increments, wrapping at PERIOD-1 -> 0. On that wrap, cycle_cnt increments, wrapping at CYCLES-1 -> 0. On that wrap, burst_cnt increments (saturating).
- light = (state==RING) && (step_cnt < ON_STEPS).
- Auto-stop:
  - Condition: MAX_BURSTS!=0 and a burst wrap occurs with burst_cnt==MAX_BURSTS-1.
  - Result: -> IDLE, and done=1 for exactly one clock.
- stop=1 in RING or SNOOZE: -> IDLE next edge, counters cleared, no done pulse. stop in IDLE has no effect.
- snooze=1 in RING:
  - -> SNOOZE, snooze_cnt loaded with SNOOZE_STEPS-1.
  - step/cycle/burst counters are held.
  - light=0 while in SNOOZE.
- SNOOZE:
  - On tick, snooze_cnt decrements.
  - On tick with snooze_cnt==0: -> RING with step_cnt=0, cycle_cnt=0, burst_cnt preserved.
  - Holding snooze high in SNOOZE does not reload the counter.
- start=1 in SNOOZE: -> RING immediately, step/cycle cleared, burst_cnt preserved.
- start=1 in RING: ignored; no pattern restart.
- Simultaneous tick and stop: stop wins; no step advance and no done pulse.
- Reset mid-operation: immediate IDLE, light drops asynchronously.
- Counter widths are $clog2 of each range, with a minimum of 1 bit.
- Parameter legality is checked by elaboration-time assertions.

Optional Feature:
- Macro: NAP_ALARM_SNOOZE_EN.
- Defined: SNOOZE state and the `snooze` input behave as above.
- Undefined: the `snooze` port remains but is ignored, and the SNOOZE state and snooze_cnt are not built. state_o never reports 2.

Decomposition:
- Package nap_alarm_pkg holds:
  - the state typedef (2-bit enum IDLE/RING/SNOOZE);
  - STATE_W=2;
  - a constant function for safe counter width (clog2, min 1).
- One sub-module, alarm_tick_div: the prescaler with a clear input, producing a one-clock `tick` every CLK_DIV enables.

Test Plan:
- Defaults, start pulse then run 24 clocks -> light pattern 100100100100 repeated twice; active=1 throughout.
- CLK_DIV=4, PERIOD=4, ON_STEPS=2 -> light high 8 clocks, low 8 clocks, with the first rise one clock after start.
- MAX_BURSTS=2 with defaults -> after 24 clocks of RING: state IDLE, done=1 for one clock, light=0.
- SNOOZE_STEPS=5, snooze asserted at step 1 of burst 0 -> light=0 for 5 clocks, then RING at step 0, light=1; burst_cnt unchanged.
- stop and snooze asserted together in RING -> IDLE next edge, done=0. start asserted in RING mid-pattern -> pattern unaffected.
- Reset low mid-RING -> light=0 and state_o=0 without a clock edge. Release with start=1 -> RING one clock later.
